// File: rtl/fp_op_sequencer.sv
// rtl/fp_op_sequencer.sv - single-issue add/mul/div sequencer with a shared operand bus
// Holds operands stable, pulses the divider start, and returns tagged results with status.
module fp_op_sequencer #(
   parameter int TAG_W       = 4,
   parameter int ADD_LAT     = 1,
   parameter int MUL_LAT     = 2,
   parameter int DIV_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_opcode,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      op_a,
   output logic [31:0]      op_b,
   input  logic [31:0]      add_result,
   input  logic [31:0]      mul_result,
   output logic             div_start,
   input  logic [31:0]      div_result,
   input  logic             div_complete,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [1:0]       rsp_status,
   output logic             busy,
   output logic [15:0]      op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ILLEGAL = 2'b01;
   localparam logic [1:0] ST_DIVZERO = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   localparam int CNT_MAX_AM = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int CNT_MAX    = (CNT_MAX_AM > DIV_TIMEOUT) ? CNT_MAX_AM : DIV_TIMEOUT;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         opc_q, opc_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [31:0]        op_a_q, op_a_d;
   logic [31:0]        op_b_q, op_b_d;
   logic [31:0]        rsp_result_q, rsp_result_d;
   logic [1:0]         rsp_status_q, rsp_status_d;
   logic [15:0]        op_count_q, op_count_d;
   logic               div_start_q, div_start_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      opc_d        = opc_q;
      tag_d        = tag_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_result_d = rsp_result_q;
      rsp_status_d = rsp_status_q;
      op_count_d   = op_count_q;
      div_start_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_a_d = req_a;
               op_b_d = req_b;
               opc_d  = req_opcode;
               tag_d  = req_tag;
               cnt_d  = '0;
               if (req_opcode == OP_ILL) begin
                  rsp_result_d = '0;
                  rsp_status_d = ST_ILLEGAL;
                  state_d      = RESP;
               end else if (req_opcode == OP_DIV && req_b[30:0] == 31'd0) begin
                  // Both signed zeros count as divide-by-zero; the divider is never started.
                  rsp_result_d = '0;
                  rsp_status_d = ST_DIVZERO;
                  state_d      = RESP;
               end else begin
                  state_d     = EXEC;
                  div_start_d = (req_opcode == OP_DIV);
               end
            end
         end

         EXEC: begin
            cnt_d = cnt_q + 1'b1;
            case (opc_q)
               OP_ADD: begin
                  if (cnt_q == CNT_W'(ADD_LAT - 1)) begin
                     rsp_result_d = add_result;
                     rsp_status_d = ST_OK;
                     state_d      = RESP;
                  end
               end
               OP_MUL: begin
                  if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                     rsp_result_d = mul_result;
                     rsp_status_d = ST_OK;
                     state_d      = RESP;
                  end
               end
               OP_DIV: begin
                  // A complete seen alongside the start pulse is left over from a previous divide.
                  if (div_complete && !div_start_q) begin
                     rsp_result_d = div_result;
                     rsp_status_d = ST_OK;
                     state_d      = RESP;
                  end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                     rsp_result_d = '0;
                     rsp_status_d = ST_TIMEOUT;
                     state_d      = RESP;
                  end
               end
               default: begin
                  rsp_result_d = '0;
                  rsp_status_d = ST_ILLEGAL;
                  state_d      = RESP;
               end
            endcase
         end

         RESP: begin
            if (rsp_ready) begin
               op_count_d = op_count_q + 16'd1;
               state_d    = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         opc_q        <= OP_ADD;
         tag_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_result_q <= '0;
         rsp_status_q <= ST_OK;
         op_count_q   <= '0;
         div_start_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         opc_q        <= opc_d;
         tag_q        <= tag_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_status_q <= rsp_status_d;
         op_count_q   <= op_count_d;
         div_start_q  <= div_start_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign div_start  = div_start_q;
   assign rsp_result = rsp_result_q;
   assign rsp_tag    = tag_q;
   assign rsp_status = rsp_status_q;
   assign op_count   = op_count_q;

endmodule
